// File: rtl/ram_if.sv
// ram_if: signal bundle between a single bus master and the ram scratch-pad.
//   clk    - bench/system clock that the bundle is synchronous to
//   reset  - synchronous active-high reset, driven by the master
//   wr_en  - 1 = write cycle, 0 = read cycle
//   addr   - word address shared by reads and writes
//   wdata  - write data
//   rdata  - registered read data returned by the memory
interface ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input logic clk
);
    logic                  reset;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    // The memory receives reset on its own scalar port, so the slave view
    // carries only the access signals.
    modport master (
        input  clk,
        output reset,
        output wr_en,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  wr_en,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/ram.sv
// ram: single-port synchronous scratch-pad RAM with a registered read port
// and a one-cycle synchronous clear of the whole array.
//   clk   - single clock, everything sampled on the rising edge
//   reset - synchronous active-high; clears every word and rdata
//   bus   - ram_if slave view: wr_en, addr, wdata in; rdata out
// Each edge performs exactly one operation: reset, else write, else read.
// A write leaves rdata unchanged (no read-during-write forwarding).
module ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // The array lives in flops rather than a RAM macro so it can be cleared
    // in a single cycle.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Next-state for array and read register; reset priority is handled in
    // the register process so these only cover the write/read choice.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (bus.wr_en) begin
            mem_d[bus.addr] = bus.wdata;
        end else begin
            rdata_d = mem_q[bus.addr];
        end
    end

    // State registers with synchronous clear of every word and of rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_ram.sv
// tb_ram: scoreboard bench for ram. Each stimulus cycle pushes the rdata value
// the memory must show after that edge; an independent monitor pops and
// compares one entry shortly after every rising edge.
module tb_ram;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus (.clk(clk));

    ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (bus.reset),
        .bus   (bus.slave)
    );

    logic [DW-1:0] exp_q  [$];
    string         name_q [$];
    int            errors = 0;
    int            checks = 0;

    // One cycle of stimulus, driven mid-cycle, with its expected rdata.
    task automatic op(input logic rst, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] exp,
                      input string nm);
        @(negedge clk);
        bus.reset = rst;
        bus.wr_en = we;
        bus.addr  = a;
        bus.wdata = d;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor: after each rising edge, compare rdata with the oldest entry.
    initial begin
        logic [DW-1:0] e;
        string         n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (bus.rdata !== e) begin
                    errors++;
                    $display("FAIL %s: rdata=%h expected=%h", n, bus.rdata, e);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        bus.reset = 1'b0;
        bus.wr_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);

        // Reset, then every address reads 0.
        op(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, "reset_rdata");
        for (int i = 0; i < 16; i++) op(1'b0, 1'b0, 4'(i), 8'h00, 8'h00, "reset_clear");

        // Write 0xA5 to addr 3 (rdata holds 0), then read it back.
        op(1'b0, 1'b1, 4'd3, 8'hA5, 8'h00, "write_hold");
        op(1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, "read_a5");

        // Sweep: write addr+0x10 everywhere (rdata holds 0xA5), then read back.
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 4'(i), 8'(8'h10 + i), 8'hA5, "sweep_hold");
        for (int i = 0; i < 16; i++) op(1'b0, 1'b0, 4'(i), 8'h00, 8'(8'h10 + i), "sweep_read");

        // Same-address overwrite at the top address; addr 0 untouched.
        op(1'b0, 1'b1, 4'd15, 8'hFF, 8'h1F, "ovw_hold1");
        op(1'b0, 1'b1, 4'd15, 8'h01, 8'h1F, "ovw_hold2");
        op(1'b0, 1'b0, 4'd15, 8'h00, 8'h01, "ovw_read15");
        op(1'b0, 1'b0, 4'd0,  8'h00, 8'h10, "addr0_keep");

        // Read 0x22 from addr 2, then write 0x99 to addr 7: rdata stays 0x22.
        op(1'b0, 1'b1, 4'd2, 8'h22, 8'h10, "set2_hold");
        op(1'b0, 1'b0, 4'd2, 8'h00, 8'h22, "read2");
        op(1'b0, 1'b1, 4'd7, 8'h99, 8'h22, "rdw_hold");
        op(1'b0, 1'b0, 4'd7, 8'h00, 8'h99, "read7");

        // wr_en toggling every cycle.
        op(1'b0, 1'b1, 4'd4, 8'h5A, 8'h99, "tog_w1");
        op(1'b0, 1'b0, 4'd4, 8'h00, 8'h5A, "tog_r1");
        op(1'b0, 1'b1, 4'd4, 8'h3C, 8'h5A, "tog_w2");
        op(1'b0, 1'b0, 4'd4, 8'h00, 8'h3C, "tog_r2");

        // Reset coincident with a write of 0x77 to addr 5: write discarded.
        op(1'b1, 1'b1, 4'd5, 8'h77, 8'h00, "midrst_rdata");
        op(1'b0, 1'b0, 4'd5, 8'h00, 8'h00, "midrst_addr5");
        for (int i = 0; i < 16; i++) op(1'b0, 1'b0, 4'(i), 8'h00, 8'h00, "midrst_clear");

        // Idle reads of addr 0 (still 0) while the monitor drains the queue.
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.addr  = '0;
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
